// File: rtl/iob_eth_mii_rx_framer.sv
// MII receive framer: preamble/SFD detection, nibble-to-byte assembly, sof/eof and frame status.
// Optional FCS checking is compiled in when ETH_RX_FCS_CHECK_EN is defined.
module iob_eth_mii_rx_framer #(
  parameter int MIN_PRE_NIB = 4,
  parameter int MAX_LEN     = 1518,
  parameter int MIN_LEN     = 64
) (
  input  logic        RX_CLK,
  input  logic        rx_rst,
  input  logic        RX_DV,
  input  logic        RX_ER,
  input  logic [3:0]  RX_DATA,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic [10:0] len_o,
  output logic        rxer_err_o,
  output logic        align_err_o,
  output logic        len_err_o,
  output logic        short_err_o,
  output logic        fcs_err_o
);
  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t      state, state_n;
  logic        dv, er;
  logic [3:0]  nib, low;
  logic [3:0]  pre_cnt;
  logic [10:0] len;
  logic        phase, rxer, from_data;
  logic        start, emit, ovf, finish, drop_eof;

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    emit     = 1'b0;
    ovf      = 1'b0;
    finish   = 1'b0;
    drop_eof = 1'b0;
    case (state)
      IDLE: if (dv) state_n = (nib == 4'h5) ? PRE : DROP;
      PRE: begin
        if (!dv) state_n = IDLE;
        else if (er) state_n = DROP;
        else if (nib == 4'hD && pre_cnt >= 4'(MIN_PRE_NIB)) begin
          state_n = DATA;
          start   = 1'b1;
        end else if (nib != 4'h5) state_n = DROP;
      end
      DATA: begin
        if (!dv) begin
          state_n = IDLE;
          finish  = 1'b1;
        end else if (phase) begin
          if (len == 11'(MAX_LEN)) begin
            ovf     = 1'b1;
            state_n = DROP;
          end else emit = 1'b1;
        end
      end
      DROP: if (!dv) begin
        state_n  = IDLE;
        drop_eof = from_data;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK or posedge rx_rst) begin
    if (rx_rst) begin
      dv <= 1'b0; er <= 1'b0; nib <= '0; low <= '0;
      state <= IDLE; pre_cnt <= '0; len <= '0; phase <= 1'b0;
      rxer <= 1'b0; from_data <= 1'b0;
      byte_o <= '0; byte_valid_o <= 1'b0; sof_o <= 1'b0; eof_o <= 1'b0;
      len_o <= '0; rxer_err_o <= 1'b0; align_err_o <= 1'b0;
      len_err_o <= 1'b0; short_err_o <= 1'b0;
    end else begin
      dv  <= RX_DV;
      er  <= RX_ER;
      nib <= RX_DATA;
      state <= state_n;

      if (state == IDLE && dv && nib == 4'h5) pre_cnt <= 4'd1;
      else if (state == PRE && nib == 4'h5 && pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;

      if (start) begin
        phase <= 1'b0;
        len   <= '0;
        rxer  <= 1'b0;
      end else if (state == DATA && dv) begin
        phase <= ~phase;
        if (!phase) low <= nib;
        if (er) rxer <= 1'b1;
      end

      // DROP only reports an eof when it was reached by overflowing a frame
      if (ovf) from_data <= 1'b1;
      else if (state_n == IDLE) from_data <= 1'b0;

      byte_valid_o <= emit;
      sof_o        <= emit && len == '0;
      eof_o        <= finish || drop_eof;
      if (emit) begin
        byte_o <= {nib, low};
        len    <= len + 11'd1;
      end

      if (emit && len == '0) begin
        len_o <= '0; rxer_err_o <= 1'b0; align_err_o <= 1'b0;
        len_err_o <= 1'b0; short_err_o <= 1'b0;
      end else if (finish || drop_eof) begin
        len_o       <= len;
        rxer_err_o  <= rxer;
        align_err_o <= finish && phase;
        len_err_o   <= drop_eof;
        short_err_o <= len < 11'(MIN_LEN);
      end
    end
  end

`ifdef ETH_RX_FCS_CHECK_EN
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  logic [31:0] crc;

  // Running over data plus FCS leaves the fixed CRC-32 residue on a clean frame
  always_ff @(posedge RX_CLK or posedge rx_rst) begin
    if (rx_rst) begin
      crc       <= 32'hFFFFFFFF;
      fcs_err_o <= 1'b0;
    end else begin
      if (start) crc <= 32'hFFFFFFFF;
      else if (emit) crc <= crc_byte(crc, {nib, low});
      if (emit && len == '0) fcs_err_o <= 1'b0;
      else if (finish) fcs_err_o <= phase || (crc != 32'hDEBB20E3);
      else if (drop_eof) fcs_err_o <= 1'b1;
    end
  end
`else
  assign fcs_err_o = 1'b0;
`endif
endmodule
